pack_rec_mc: RTL

Clocked, synthesizable multi-channel packet receiver for two-phase (transition-signalled) bundled-data links coming out of the asynchronous MouseTrap pipelines.
- Per channel: synchronizes req, captures the flit, returns ack after a programmable delay, tracks packet framing via a tail bit, and counts packets.
- Captured flits from all channels are merged onto one valid/ready stream by a round-robin arbiter, feeding on-chip checkers and loggers.

---
 rtl/pack_rec_mc_pkg.sv | 14 +
 rtl/pack_rec_mc_if.sv | 32 +++
 rtl/pack_rec_mc_chan.sv | 124 ++++++++++++
 rtl/pack_rec_mc.sv | 107 ++++++++++
 4 files changed

// File: rtl/pack_rec_mc_pkg.sv
// Shared types and helpers for the multi-channel two-phase packet receiver.
package pack_rec_mc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hs_state_t;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pack_rec_mc_if.sv
// Bundle of the per-channel two-phase links, the merged output stream and status.
interface pack_rec_mc_if
  import pack_rec_mc_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int N_CH       = 4,
  parameter int CNT_WIDTH  = 32
);
  localparam int CH_W = ch_w(N_CH);

  logic [N_CH-1:0]                 req;
  logic [N_CH-1:0]                 ack;
  logic [N_CH-1:0][WORD_WIDTH-1:0] data;
  logic                            out_valid;
  logic                            out_ready;
  logic [WORD_WIDTH-1:0]           out_data;
  logic [CH_W-1:0]                 out_ch;
  logic                            out_last;
  logic [N_CH-1:0][CNT_WIDTH-1:0]  packet_rx;
  logic [N_CH-1:0]                 len_err;

  modport master (
    output req, data, out_ready,
    input  ack, out_valid, out_data, out_ch, out_last, packet_rx, len_err
  );

  modport slave (
    input  req, data, out_ready,
    output ack, out_valid, out_data, out_ch, out_last, packet_rx, len_err
  );

endinterface

// File: rtl/pack_rec_mc_chan.sv
// One receive channel: req synchronizer, two-phase handshake FSM, single-flit
// capture buffer, packet framing counters and sticky over-length flag.
module pack_rec_mc_chan
  import pack_rec_mc_pkg::*;
#(
  parameter int WORD_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_DELAY   = 1,
  parameter int TAIL_BIT    = 1,
  parameter int MAX_FLITS   = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic                  ack_o,
  output logic                  full_o,
  output logic [WORD_WIDTH-1:0] buf_o,
  output logic [CNT_WIDTH-1:0]  packet_rx_o,
  output logic                  len_err_o
);

  localparam int DLY_W = (ACK_DELAY > 0) ? $clog2(ACK_DELAY + 1) : 1;
  localparam int FC_W  = $clog2(MAX_FLITS + 1);

  localparam logic [DLY_W-1:0]     DLY_LOAD = DLY_W'(ACK_DELAY);
  localparam logic [DLY_W-1:0]     DLY_ONE  = DLY_W'(1);
  localparam logic [FC_W-1:0]      FC_MAX   = FC_W'(MAX_FLITS);
  localparam logic [FC_W-1:0]      FC_LAST  = FC_W'(MAX_FLITS - 1);
  localparam logic [FC_W-1:0]      FC_ONE   = FC_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  hs_state_t              state_q;
  logic [DLY_W-1:0]       dly_q;
  logic                   ack_q;
  logic                   full_q;
  logic [WORD_WIDTH-1:0]  buf_q;
  logic [FC_W-1:0]        flit_cnt_q;
  logic [CNT_WIDTH-1:0]   pkt_q;
  logic                   len_err_q;

  logic                   req_s;
  logic                   pending;
  logic                   capture;
  logic                   tail;
  logic                   len_hit;
  logic [FC_W-1:0]        flit_cnt_d;
  logic [CNT_WIDTH-1:0]   pkt_d;

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign pending = req_s != ack_q;
  // A full buffer stalls capture and therefore the ack: this is the backpressure path.
  assign capture = (state_q == IDLE) && pending && !full_q;

  always_comb begin
    tail       = data_i[TAIL_BIT];
    len_hit    = !tail && (flit_cnt_q == FC_LAST);
    pkt_d      = pkt_q;
    flit_cnt_d = flit_cnt_q;
    if (tail) begin
      pkt_d      = pkt_q + CNT_ONE;
      flit_cnt_d = '0;
    end else if (flit_cnt_q != FC_MAX) begin
      flit_cnt_d = flit_cnt_q + FC_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      state_q    <= IDLE;
      dly_q      <= '0;
      ack_q      <= 1'b0;
      full_q     <= 1'b0;
      buf_q      <= '0;
      flit_cnt_q <= '0;
      pkt_q      <= '0;
      len_err_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
      if (pop_i) begin
        full_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (capture) begin
            // data_i is safe to sample raw: req_s trails req by the synchronizer depth.
            buf_q      <= data_i;
            full_q     <= 1'b1;
            flit_cnt_q <= flit_cnt_d;
            pkt_q      <= pkt_d;
            if (len_hit) begin
              len_err_q <= 1'b1;
            end
            if (ACK_DELAY == 0) begin
              ack_q <= ~ack_q;
            end else begin
              state_q <= HOLD;
              dly_q   <= DLY_LOAD;
            end
          end
        end
        HOLD: begin
          dly_q <= dly_q - DLY_ONE;
          if (dly_q == DLY_ONE) begin
            ack_q   <= ~ack_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_o       = ack_q;
  assign full_o      = full_q;
  assign buf_o       = buf_q;
  assign packet_rx_o = pkt_q;
  assign len_err_o   = len_err_q;

endmodule

// File: rtl/pack_rec_mc.sv
// Multi-channel two-phase packet receiver: N_CH channel front-ends merged onto
// one valid/ready stream by a round-robin arbiter with a stall-frozen grant.
module pack_rec_mc
  import pack_rec_mc_pkg::*;
#(
  parameter int WORD_WIDTH  = 32,
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_DELAY   = 1,
  parameter int TAIL_BIT    = 1,
  parameter int MAX_FLITS   = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic         clk,
  input  logic         reset,
  pack_rec_mc_if.slave bus_if
);

  localparam int CH_W = ch_w(N_CH);

  logic [N_CH-1:0]                 full_w;
  logic [N_CH-1:0]                 pop_w;
  logic [N_CH-1:0]                 ack_w;
  logic [N_CH-1:0]                 len_err_w;
  logic [N_CH-1:0][WORD_WIDTH-1:0] buf_w;
  logic [N_CH-1:0][CNT_WIDTH-1:0]  pkt_w;

  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] ptr_d;
  logic [CH_W-1:0] hold_gnt_q;
  logic            hold_q;
  logic            hold_d;
  logic [CH_W-1:0] rr_gnt;
  logic [CH_W-1:0] gnt;
  logic            rr_found;
  int              rr_idx;
  logic            any_full;
  logic            xfer;

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    pack_rec_mc_chan #(
      .WORD_WIDTH (WORD_WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .ACK_DELAY  (ACK_DELAY),
      .TAIL_BIT   (TAIL_BIT),
      .MAX_FLITS  (MAX_FLITS),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .req_i      (bus_if.req[c]),
      .data_i     (bus_if.data[c]),
      .pop_i      (pop_w[c]),
      .ack_o      (ack_w[c]),
      .full_o     (full_w[c]),
      .buf_o      (buf_w[c]),
      .packet_rx_o(pkt_w[c]),
      .len_err_o  (len_err_w[c])
    );

    assign pop_w[c] = xfer && (gnt == CH_W'(c));
  end

  // First full channel at or after the pointer, scanning with wrap-around.
  always_comb begin
    rr_gnt   = ptr_q;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int i = 0; i < N_CH; i++) begin
      rr_idx = (int'(ptr_q) + i) % N_CH;
      if (!rr_found && full_w[rr_idx]) begin
        rr_found = 1'b1;
        rr_gnt   = CH_W'(rr_idx);
      end
    end
  end

  // A stalled grant is replayed from hold_gnt_q so late arrivals cannot preempt it.
  assign any_full = |full_w;
  assign gnt      = hold_q ? hold_gnt_q : rr_gnt;
  assign xfer     = any_full && bus_if.out_ready;
  assign hold_d   = any_full && !bus_if.out_ready;
  assign ptr_d    = xfer ? CH_W'((int'(gnt) + 1) % N_CH) : ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      hold_q     <= 1'b0;
      hold_gnt_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      hold_q <= hold_d;
      if (hold_d) begin
        hold_gnt_q <= gnt;
      end
    end
  end

  assign bus_if.ack       = ack_w;
  assign bus_if.out_valid = any_full;
  assign bus_if.out_data  = buf_w[gnt];
  assign bus_if.out_ch    = gnt;
  assign bus_if.out_last  = buf_w[gnt][TAIL_BIT];
  assign bus_if.packet_rx = pkt_w;
  assign bus_if.len_err   = len_err_w;

endmodule
